// File: rtl/dmem_responder.sv
// Multi-cycle data memory: sized/extended loads, byte-lane stores, range error.
// Define DMEM_MISALIGN_TRAP_EN to reject misaligned accesses instead of aligning them.
module dmem_responder #(
  parameter int DEPTH_WORDS = 512,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          IW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [63:0] BYTE_LIMIT = 64'(DEPTH_WORDS) * 64'd8;
  localparam logic [3:0]  LAT4       = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        lat_we;
  logic        lat_unsigned;
  logic [1:0]  lat_size;
  logic [63:0] lat_addr;
  logic [63:0] lat_wdata;

  logic [63:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        commit;
  logic        live;
  logic        op_we;
  logic        op_unsigned;
  logic [1:0]  op_size;
  logic [63:0] op_addr;
  logic [63:0] op_wdata;

  logic [2:0]  align_mask;
  logic [2:0]  off;
  logic [63:0] eff_addr;
  logic [IW-1:0] word_idx;
  logic        out_of_range;
  logic        acc_err;
  logic [7:0]  size_bytes;
  logic [7:0]  wr_mask;
  logic [63:0] wr_data;
  logic        wr_en;
  logic [63:0] rd_word;
  logic [63:0] rd_shift;
  logic [63:0] rd_ext;
  logic [63:0] rdata_next;

  assign accept = (state == IDLE) && req_valid && req_ready;
  assign commit = ((LATENCY == 0) && accept) || ((state == WAIT) && (cnt == 4'd1));

  // With zero wait states the access commits on the acceptance edge, so it must
  // see the live request; otherwise it uses the captured copy.
  assign live        = (state == IDLE);
  assign op_we       = live ? req_we       : lat_we;
  assign op_unsigned = live ? req_unsigned : lat_unsigned;
  assign op_size     = live ? req_size     : lat_size;
  assign op_addr     = live ? req_addr     : lat_addr;
  assign op_wdata    = live ? req_wdata    : lat_wdata;

  always_comb begin
    align_mask = 3'b000;
    size_bytes = 8'h00;
    case (op_size)
      2'd0:    begin align_mask = 3'b000; size_bytes = 8'h01; end
      2'd1:    begin align_mask = 3'b001; size_bytes = 8'h03; end
      2'd2:    begin align_mask = 3'b011; size_bytes = 8'h0F; end
      default: begin align_mask = 3'b111; size_bytes = 8'hFF; end
    endcase

    eff_addr     = {op_addr[63:3], op_addr[2:0] & ~align_mask};
    off          = eff_addr[2:0];
    out_of_range = (eff_addr >= BYTE_LIMIT);
`ifdef DMEM_MISALIGN_TRAP_EN
    acc_err      = out_of_range || ((op_addr[2:0] & align_mask) != 3'b000);
`else
    acc_err      = out_of_range;
`endif
    word_idx     = eff_addr[IW+2:3];

    wr_mask = size_bytes << off;
    wr_data = op_wdata << {off, 3'b000};

    rd_word  = out_of_range ? 64'd0 : mem[word_idx];
    rd_shift = rd_word >> {off, 3'b000};
    rd_ext   = rd_shift;
    case (op_size)
      2'd0: rd_ext = op_unsigned ? {56'd0, rd_shift[7:0]}
                                 : {{56{rd_shift[7]}}, rd_shift[7:0]};
      2'd1: rd_ext = op_unsigned ? {48'd0, rd_shift[15:0]}
                                 : {{48{rd_shift[15]}}, rd_shift[15:0]};
      2'd2: rd_ext = op_unsigned ? {32'd0, rd_shift[31:0]}
                                 : {{32{rd_shift[31]}}, rd_shift[31:0]};
      default: rd_ext = rd_shift;
    endcase

    rdata_next = (op_we || acc_err) ? 64'd0 : rd_ext;
  end

  // Reset forces IDLE with req_ready low, so an abandoned store can never commit.
  assign wr_en = commit && op_we && !acc_err;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 8; b++) begin
        if (wr_mask[b]) mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      req_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 64'd0;
      rsp_err      <= 1'b0;
      lat_we       <= 1'b0;
      lat_unsigned <= 1'b0;
      lat_size     <= 2'd0;
      lat_addr     <= 64'd0;
      lat_wdata    <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          if (!req_ready) begin
            req_ready <= 1'b1;
          end else if (req_valid) begin
            req_ready    <= 1'b0;
            lat_we       <= req_we;
            lat_unsigned <= req_unsigned;
            lat_size     <= req_size;
            lat_addr     <= req_addr;
            lat_wdata    <= req_wdata;
            cnt          <= LAT4;
            if (LATENCY == 0) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= rdata_next;
              rsp_err   <= acc_err;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd1) begin
            state     <= RESP;
            cnt       <= 4'd0;
            rsp_valid <= 1'b1;
            rsp_rdata <= rdata_next;
            rsp_err   <= acc_err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
